alu_out_uart_tx: RTL

//  Downstream output stage of the 8-bit computer: captures ALU result bytes
//  (alu_out) on a strobe, buffers them in a small FIFO and serialises each byte
//  as a UART 8N1 frame on a single tx line.

---
 rtl/alu_out_uart_tx.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/alu_out_uart_tx.sv
// alu_out_uart_tx: captures ALU result bytes into a small FIFO and sends each
// one as a UART 8N1 frame (start bit, 8 data bits LSB first, stop bit) on tx.
module alu_out_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       overflow_clr,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [BW-1:0] baud_q, baud_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          overflow_q, overflow_d;

  logic push, pop, drop, baud_tc;

  // FIFO status comes straight from the registered count
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;

  // A pop happens exactly when the FSM leaves IDLE; a push may use the slot it frees
  assign pop     = (state_q == S_IDLE) && !fifo_empty;
  assign push    = data_valid && (!fifo_full || pop);
  assign drop    = data_valid && fifo_full && !pop;
  assign baud_tc = (baud_q == BW'(CLKS_PER_BIT - 1));

  // Next-state logic for FIFO, overflow flag and transmit FSM
  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    baud_d     = baud_q;
    tx_d       = tx_q;
    overflow_d = overflow_q;

    if (push) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // A drop in the same cycle as a clear leaves the flag set
    if (drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          shift_d   = mem_q[rd_ptr_q];
          bit_idx_d = '0;
          baud_d    = '0;
          tx_d      = 1'b0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (baud_tc) begin
          baud_d  = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_tc) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (baud_tc) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        baud_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_d = (state_d != S_IDLE);

  // All state registered here; reset abandons any frame and empties the FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      baud_q     <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      baud_q     <= baud_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
